dbg_loader: RTL and testbench

- Serial-side debug loader driving the SoC debug memory port (dbg_mem_op, dbg_wren, dbg_adr, dbg_do) and the CPU reset gate (cpu_n_reset).
- Consumes bytes from the UART receiver and sends status bytes to the UART transmitter.
- Replaces bench-forced ROM programming with a host protocol: halt the CPU, write words, release the CPU.

---
 rtl/dbg_loader_if.sv | 30 +++
 rtl/dbg_loader.sv | 214 +++++++++++++++++++++
 tb/tb_dbg_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_loader_if.sv
// Byte stream in, status byte out and debug memory/CPU-reset port of dbg_loader.
// master = loader side, slave = UART/SoC side.
interface dbg_loader_if;
    // rx: rx_valid is a one-cycle strobe with no back-pressure.
    // tx: a byte moves when tx_valid && tx_ready on a rising clk edge. tx_valid
    //     and tx_data hold steady until that edge.
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        cpu_n_reset;
    logic        overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
               cpu_n_reset, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
               cpu_n_reset, overrun
    );
endinterface

// File: rtl/dbg_loader.sv
// Serial debug loader: W/H/R host commands drive the debug memory port and CPU reset.
// Optional DBG_LOADER_CHECKSUM_EN adds an XOR checksum byte to every W frame.
module dbg_loader #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BOOT_HALTED    = 0
) (
    input  logic         clk,
    input  logic         n_reset,
    dbg_loader_if.master bus,
    output logic [2:0]   state_o
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef DBG_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM  = 3'd3;
`endif
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          cpu_q, cpu_d;
    logic          mem_op_q, mem_op_d;
    logic          overrun_q, overrun_d;
    logic          in_frame;
    logic          launch;
`ifdef DBG_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;

    assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        data_d     = data_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cpu_d      = cpu_q;
        mem_op_d   = mem_op_q;
        overrun_d  = bus.rx_valid && ((state_q == ST_WRITE) || (state_q == ST_RESP));
        launch     = 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        // Inter-byte idle watchdog; a stalled host frame is dropped without a reply.
        if (in_frame) begin
            if (bus.rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_W) begin
                        state_d = ST_ADDR;
                        cnt_d   = 2'd0;
                        tmo_d   = '0;
`ifdef DBG_LOADER_CHECKSUM_EN
                        csum_d  = 8'h00;
`endif
                    end else begin
                        state_d    = ST_RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ACK;
                        if (bus.rx_data == CMD_H)      cpu_d = 1'b0;
                        else if (bus.rx_data == CMD_R) cpu_d = 1'b1;
                        else                           tx_data_d = NAK;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    adr_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    cnt_d = cnt_q + 2'd1;
`ifdef DBG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    if (cnt_q == 2'd3) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    data_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
                    cnt_d = cnt_q + 2'd1;
`ifdef DBG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
                    if (cnt_q == 2'd3) state_d = ST_CSUM;
`else
                    if (cnt_q == 2'd3) launch = 1'b1;
`endif
                end
            end
`ifdef DBG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        launch = 1'b1;
                    end else begin
                        state_d    = ST_RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK;
                    end
                end
            end
`endif
            ST_WRITE: begin
                if (hold_q == HOLD_LAST) begin
                    mem_op_d   = 1'b0;
                    state_d    = ST_RESP;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_RESP: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Address is complete once the frame is; unaligned words are refused.
        if (launch) begin
            if (adr_q[1:0] != 2'b00) begin
                state_d    = ST_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = NAK;
            end else begin
                state_d  = ST_WRITE;
                mem_op_d = 1'b1;
                hold_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            adr_q      <= 32'h0;
            data_q     <= 32'h0;
            tmo_q      <= '0;
            hold_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cpu_q      <= (BOOT_HALTED == 0);
            mem_op_q   <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cpu_q      <= cpu_d;
            mem_op_q   <= mem_op_d;
            overrun_q  <= overrun_d;
`ifdef DBG_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.dbg_mem_op  = mem_op_q;
    assign bus.dbg_wren    = {4{mem_op_q}};
    assign bus.dbg_adr     = adr_q;
    assign bus.dbg_do      = data_q;
    assign bus.cpu_n_reset = cpu_q;
    assign bus.overrun     = overrun_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_dbg_loader.sv
// Bench for dbg_loader: directed host frames plus random frames scored against a frame-level model.
module tb_dbg_loader;
    localparam int HOLD = 4;
    localparam int TMO  = 40;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [2:0] state;

    dbg_loader_if bus();

    dbg_loader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .BOOT_HALTED(0)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus), .state_o(state)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frame[$];
    bit         model_cpu = 1'b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: what the host should see for the bytes in frame.
    task automatic model_frame(output bit wr, output logic [31:0] adr, output logic [31:0] dat);
        logic [7:0] resp;
        wr = 1'b0; adr = 32'h0; dat = 32'h0; resp = 8'h15;
        case (frame[0])
            8'h48: begin model_cpu = 1'b0; resp = 8'h06; end
            8'h52: begin model_cpu = 1'b1; resp = 8'h06; end
            8'h57: begin
                adr = {frame[4], frame[3], frame[2], frame[1]};
                dat = {frame[8], frame[7], frame[6], frame[5]};
                wr  = (adr % 4 == 0);
`ifdef DBG_LOADER_CHECKSUM_EN
                begin
                    logic [7:0] x;
                    x = 8'h00;
                    for (int i = 1; i <= 8; i++) x ^= frame[i];
                    if (frame[9] != x) wr = 1'b0;
                end
`endif
                if (wr) resp = 8'h06;
            end
            default: ;
        endcase
        exp_q.push_back(resp);
    endtask

    task automatic build_w(input logic [31:0] adr, input logic [31:0] dat, input bit bad_csum);
        logic [7:0] x;
        x = 8'h00;
        frame = {};
        frame.push_back(8'h57);
        for (int i = 0; i < 4; i++) frame.push_back(adr[8*i +: 8]);
        for (int i = 0; i < 4; i++) frame.push_back(dat[8*i +: 8]);
        for (int i = 1; i <= 8; i++) x ^= frame[i];
`ifdef DBG_LOADER_CHECKSUM_EN
        frame.push_back(bad_csum ? 8'h00 : x);
`else
        if (bad_csum && x == 8'hFF) frame.push_back(x);
`endif
    endtask

    // Called at a negedge; leaves at the negedge after the byte is clocked in.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic accept(input string tag);
        logic [7:0] e;
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check({tag, "_tx_data"}, bus.tx_data, e);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        check({tag, "_tx_drop"}, bus.tx_valid, 0);
    endtask

    task automatic run_frame(input string tag, input int gap_max, input int stall_at, input int stall_len);
        bit          wr, seen;
        logic [31:0] adr, dat, got_adr, got_dat;
        logic [3:0]  got_wren;
        int          hi;
        model_frame(wr, adr, dat);
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            if (i == stall_at + 1) repeat (stall_len) @(negedge clk);
            send_byte(frame[i]);
        end
        if (frame[0] == 8'h48 || frame[0] == 8'h52)
            check({tag, "_cpu_n_reset"}, bus.cpu_n_reset, model_cpu);
        hi = 0; seen = 1'b0; got_adr = 0; got_dat = 0; got_wren = 0;
        for (int c = 0; c < HOLD + 20 && !seen; c++) begin
            if (bus.dbg_mem_op) begin
                if (hi == 0) begin
                    got_adr = bus.dbg_adr; got_dat = bus.dbg_do; got_wren = bus.dbg_wren;
                end
                hi++;
            end
            if (bus.tx_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_memop_cycles"}, hi, wr ? HOLD : 0);
        if (wr) begin
            check({tag, "_adr"}, got_adr, adr);
            check({tag, "_do"}, got_dat, dat);
            check({tag, "_wren"}, got_wren, 4'hF);
            check({tag, "_wren_after"}, bus.dbg_wren, 4'h0);
            check({tag, "_adr_kept"}, bus.dbg_adr, adr);
        end
        check({tag, "_resp_seen"}, seen, 1);
        if (seen) accept(tag);
    endtask

    initial begin
        int txv, mop;
        logic [31:0] a, d;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_n_reset", bus.cpu_n_reset, 1);
        check("rst_mem_op", bus.dbg_mem_op, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_wren", bus.dbg_wren, 0);
        check("rst_adr", bus.dbg_adr, 0);
        check("rst_do", bus.dbg_do, 0);
        check("rst_overrun", bus.overrun, 0);
        n_reset = 1'b1;
        @(negedge clk);

        // Halt, load three words, release
        frame = {8'h48};                               run_frame("halt", 0, -1, 0);
        build_w(32'h0002_0000, 32'h0001_07b7, 1'b0);   run_frame("w0", 0, -1, 0);
        build_w(32'h0002_0004, 32'h0007_a023, 1'b0);   run_frame("w1", 1, -1, 0);
        build_w(32'h0002_0008, 32'h0000_006f, 1'b0);   run_frame("w2", 2, -1, 0);
        frame = {8'h52};                               run_frame("release", 0, -1, 0);

        // Unaligned address and unknown command
        build_w(32'h0002_0002, $urandom, 1'b0);        run_frame("unaligned", 0, -1, 0);
        frame = {8'h3F};                               run_frame("unknown", 0, -1, 0);

        // Longest idle gap that does not abort the frame
        build_w(32'h0002_0010, $urandom, 1'b0);        run_frame("tmo_edge", 0, 2, TMO - 1);

        // Stalled frame is dropped silently, parser back in IDLE
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        txv = 0; mop = 0;
        repeat (TMO + 2) begin
            if (bus.tx_valid) txv++;
            if (bus.dbg_mem_op) mop++;
            @(negedge clk);
        end
        check("tmo_no_resp", txv, 0);
        check("tmo_no_write", mop, 0);
        frame = {8'h48};                               run_frame("after_tmo", 0, -1, 0);

        // Busy byte during RESP
        frame = {8'h48};
        begin
            bit w; logic [31:0] aa, dd;
            model_frame(w, aa, dd);
        end
        send_byte(8'h48);
        check("busy_tx_valid_pre", bus.tx_valid, 1);
        send_byte($urandom_range(255, 0));
        check("busy_overrun", bus.overrun, 1);
        check("busy_tx_valid", bus.tx_valid, 1);
        check("busy_tx_data", bus.tx_data, exp_q[0]);
        @(negedge clk);
        check("busy_overrun_pulse", bus.overrun, 0);
        accept("busy");

`ifdef DBG_LOADER_CHECKSUM_EN
        build_w(32'h0002_0000, 32'h0001_07b7, 1'b1);   run_frame("bad_csum", 0, -1, 0);
`endif

        // Random frames
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(4, 0))
                0, 1: build_w($urandom & 32'hFFFF_FFFC, $urandom, 1'b0);
                2:    build_w(($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1)), $urandom, 1'b0);
                3:    frame = {($urandom_range(1, 0) == 1) ? 8'h48 : 8'h52};
                default: begin
                    logic [7:0] c;
                    c = 8'h57;
                    while (c == 8'h57 || c == 8'h48 || c == 8'h52) c = 8'($urandom_range(255, 0));
                    frame = {c};
                end
            endcase
            run_frame("rnd", 3, -1, 0);
        end

        // Reset in the middle of a write
        a = $urandom & 32'hFFFF_FFFC; d = $urandom;
        build_w(a, d, 1'b0);
        for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
        check("midrst_memop_pre", bus.dbg_mem_op, 1);
        #2 n_reset = 1'b0;
        #1;
        check("midrst_memop", bus.dbg_mem_op, 0);
        check("midrst_wren", bus.dbg_wren, 0);
        check("midrst_cpu_n_reset", bus.cpu_n_reset, 1);
        check("midrst_tx_valid", bus.tx_valid, 0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("midrst_memop_after", bus.dbg_mem_op, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
